alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Multi-cycle controller that sequences the register-file/ALU datapath around the ALU
//  (ALUop 00 add, 01 sub, 10 and, 11 not-B). Accepts one command per valid/ready handshake.
//  Drives read, load A/B, execute/status-capture and write-back strobes in a fixed order.
//  Sits between instruction decode and the datapath.
// PARAMETERS
//  RA_W   3   register-file address width (8 registers)
//  CNT_W  16  width of completed-operation counter
// PORTS
//  clk          in   1      rising-edge clock
//  reset_n      in   1      asynchronous active-low reset
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      controller can accept (high only in IDLE)
//  cmd_aluop    in   2      ALU operation for this command
//  cmd_rd       in   RA_W   destination register
//  cmd_rn       in   RA_W   operand-A register
//  cmd_rm       in   RA_W   operand-B register
//  cmd_wb       in   1      1 = write result to rd; 0 = status-only (compare)
//  readnum      out  RA_W   register-file read address
//  writenum     out  RA_W   register-file write address
//  write        out  1      register-file write strobe
//  loada        out  1      load A register from register-file read port
//  loadb        out  1      load B register from register-file read port
//  asel         out  1      1 = force ALU A input to 16'h0000
//  aluop        out  2      ALUop to ALU (held from capture until next accept)
//  loadc        out  1      capture ALU out into C register
//  loads        out  1      capture ALU Z into status register
//  done         out  1      one-cycle pulse: command complete
//  op_count     out  CNT_W  completed commands, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - States: IDLE, LOAD_A, LOAD_B, EXEC, WRITE. Accept = cmd_valid & cmd_ready.
//  - On accept, aluop/rd/rn/rm/wb are captured into internal registers. Cmd inputs
//    are don't-care afterwards and until cmd_ready rises again.
//  - IDLE -> LOAD_A on accept if aluop != 11; IDLE -> LOAD_B if aluop == 11 (not-B
//    needs no A operand). No accept: stay in IDLE.
//  - LOAD_A: readnum = rn, loada = 1 -> LOAD_B.
//  - LOAD_B: readnum = rm, loadb = 1 -> EXEC.
//  - EXEC: loadc = 1, loads = 1, asel = (aluop == 11) -> WRITE.
//    Z is captured for every op, including status-only commands.
//  - WRITE: writenum = rd, write = wb, done = 1, op_count += 1 -> IDLE.
//  - Latency, accept edge to done cycle: 4 cycles (aluop 00/01/10), 3 cycles (aluop 11).
//  - cmd_ready is combinational on state. No accept in WRITE, so commands are back-to-back
//    no faster than 1 per 5 cycles (4 for not-B).
//  - All strobes (loada, loadb, loadc, loads, write, done) are registered-state decodes,
//    high for exactly one cycle per command, and never high in IDLE.
//  - Outside their active state: readnum = rn, writenum = rd, asel = 0 (capture values held).
//  - op_count wraps from 2^CNT_W-1 to 0 with no flag.
//  - Reset (async, any state, including mid-command):
//    state = IDLE; all strobes = 0; cmd_ready = 1 after release; aluop = 00;
//    captured rd/rn/rm = 0; wb = 0; op_count = 0. The in-flight command is discarded:
//    no write, no done.
//  - cmd_valid high during reset is ignored. The first accept can occur on the first
//    rising edge after reset_n deasserts.
// TESTING
//  1. Add: rn=1 (R1=0), rm=2 (R2=1), rd=3, wb=1
//     -> loada, loadb, loadc/loads, write on cycles 1..4; done on cycle 4; R3 = 16'h0001, Z = 0.
//  2. Not-B: aluop=11, rm=4 (R4=16'hFFFE), rd=5
//     -> loada never asserted, asel = 1 in EXEC, done on cycle 3; R5 = 16'h0001, Z = 0.
//  3. Compare: aluop=01, R1 = R2 = 16'h0003, wb=0
//     -> write stays 0, loads = 1, Z = 1; done pulses; op_count increments.
//  4. cmd_valid held high across 3 commands -> accepts exactly at IDLE cycles;
//     done spacing = 5 cycles; op_count = 3.
//  5. reset_n low during LOAD_B -> all strobes 0 immediately; no write, no done;
//     op_count = 0; cmd_ready = 1 after release.
//  6. CNT_W=2: 5 commands -> op_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences read / load A / load B / execute / write-back strobes
// around a register-file + ALU datapath, one command per valid/ready handshake.
// Latency accept edge to done: 4 cycles (add/sub/and), 3 cycles (not-B).
// Backpressure: cmd_ready is high only in IDLE.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_aluop/rd/rn/rm/wb             command fields, captured on accept
//   readnum, writenum                 register-file read/write addresses
//   write, loada, loadb, loadc, loads datapath strobes (one cycle each per command)
//   asel                              force ALU A input to zero (not-B execute)
//   aluop                             ALU operation, held from accept to next accept
//   done                              one-cycle completion pulse
//   op_count                          completed-command counter, wraps silently
module alu_seq_ctrl #(
  parameter int RA_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_aluop,
  input  logic [RA_W-1:0]  cmd_rd,
  input  logic [RA_W-1:0]  cmd_rn,
  input  logic [RA_W-1:0]  cmd_rm,
  input  logic             cmd_wb,
  output logic [RA_W-1:0]  readnum,
  output logic [RA_W-1:0]  writenum,
  output logic             write,
  output logic             loada,
  output logic             loadb,
  output logic             asel,
  output logic [1:0]       aluop,
  output logic             loadc,
  output logic             loads,
  output logic             done,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        aluop_q;
  logic [RA_W-1:0]   rd_q, rn_q, rm_q;
  logic              wb_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              loada_q, loadb_q, exec_q, write_q, done_q;
  logic              accept;

  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // not-B has no A operand, so skip the A read entirely
          state_d = (cmd_aluop == 2'b11) ? S_LOAD_B : S_LOAD_A;
        end
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_EXEC;
      S_EXEC:   state_d = S_WRITE;
      S_WRITE:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes are registered decodes of the next state, so each one is
  // high exactly while the FSM sits in its state and drops with reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      aluop_q <= 2'b00;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      wb_q    <= 1'b0;
      cnt_q   <= '0;
      loada_q <= 1'b0;
      loadb_q <= 1'b0;
      exec_q  <= 1'b0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        aluop_q <= cmd_aluop;
        rd_q    <= cmd_rd;
        rn_q    <= cmd_rn;
        rm_q    <= cmd_rm;
        wb_q    <= cmd_wb;
      end
      loada_q <= (state_d == S_LOAD_A);
      loadb_q <= (state_d == S_LOAD_B);
      exec_q  <= (state_d == S_EXEC);
      // wb_q is stable here: WRITE is only entered from EXEC, long after capture
      write_q <= (state_d == S_WRITE) & wb_q;
      done_q  <= (state_d == S_WRITE);
      // Count becomes visible the cycle after done
      if (state_q == S_WRITE) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign loada    = loada_q;
  assign loadb    = loadb_q;
  assign loadc    = exec_q;
  assign loads    = exec_q;
  assign write    = write_q;
  assign done     = done_q;
  assign asel     = exec_q & (aluop_q == 2'b11);
  assign aluop    = aluop_q;
  assign readnum  = loadb_q ? rm_q : rn_q;
  assign writenum = rd_q;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        cmd_valid;
  logic [1:0]  cmd_aluop;
  logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
  logic        cmd_wb;

  logic        cmd_ready, write, loada, loadb, asel, loadc, loads, done;
  logic [2:0]  readnum, writenum;
  logic [1:0]  aluop;
  logic [15:0] op_count;

  logic        cmd_ready2, write2, loada2, loadb2, asel2, loadc2, loads2, done2;
  logic [2:0]  readnum2, writenum2;
  logic [1:0]  aluop2;
  logic [1:0]  op_count2;

  alu_seq_ctrl #(.RA_W(3), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_aluop(cmd_aluop), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_wb(cmd_wb),
    .readnum(readnum), .writenum(writenum), .write(write), .loada(loada), .loadb(loadb),
    .asel(asel), .aluop(aluop), .loadc(loadc), .loads(loads), .done(done), .op_count(op_count)
  );

  // Narrow-counter instance runs in lockstep on the same stimulus
  alu_seq_ctrl #(.RA_W(3), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_aluop(cmd_aluop), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_wb(cmd_wb),
    .readnum(readnum2), .writenum(writenum2), .write(write2), .loada(loada2), .loadb(loadb2),
    .asel(asel2), .aluop(aluop2), .loadc(loadc2), .loads(loads2), .done(done2), .op_count(op_count2)
  );

  // Datapath driven by the controller's strobes
  logic [15:0] rf [8];
  logic [15:0] a_r, b_r, c_r, alu_out;
  logic        z_r;
  logic        pl_en;
  logic [2:0]  pl_idx;
  logic [15:0] pl_dat;

  always_comb begin
    logic [15:0] xa;
    xa = asel ? 16'h0000 : a_r;
    case (aluop)
      2'b00:   alu_out = xa + b_r;
      2'b01:   alu_out = xa - b_r;
      2'b10:   alu_out = xa & b_r;
      default: alu_out = ~b_r;
    endcase
  end

  always @(posedge clk) begin
    if (pl_en) rf[pl_idx] <= pl_dat;
    if (loada) a_r <= rf[readnum];
    if (loadb) b_r <= rf[readnum];
    if (loadc) c_r <= alu_out;
    if (loads) z_r <= (alu_out == 16'h0000);
    if (write) rf[writenum] <= c_r;
  end

  // Reference model
  logic [15:0] mdl_rf [8];
  int          mdl_cnt;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic logic [15:0] ref_res(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
    int a, b, r;
    a = int'(x);
    b = int'(y);
    case (op)
      2'd0:    r = (a + b) % 65536;
      2'd1:    r = (a - b + 65536) % 65536;
      2'd2:    r = int'(x & y);
      default: r = 65535 - b;
    endcase
    return 16'(r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Issue one command, watch its strobes cycle by cycle, end in the IDLE cycle after done.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rn,
                         input logic [2:0] rm, input logic wb);
    int g, la, lb, lc, ls, wr, asc, lat, e_lat;
    g = 0;
    @(negedge clk);
    while (!cmd_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("ready_wait", 32'(cmd_ready), 32'd1);
    chk("idle_strobes", 32'({loada, loadb, loadc, loads, write, done, asel}), 32'd0);
    cmd_valid = 1'b1; cmd_aluop = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_wb = wb;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_aluop = 2'($urandom); cmd_rd = 3'($urandom); cmd_rn = 3'($urandom);
    cmd_rm = 3'($urandom); cmd_wb = 1'($urandom);
    la = 0; lb = 0; lc = 0; ls = 0; wr = 0; asc = 0; lat = 0;
    for (int k = 1; k <= 8; k++) begin
      if (loada) begin la = k; chk("raddr_a", 32'(readnum), 32'(rn)); end
      if (loadb) begin lb = k; chk("raddr_b", 32'(readnum), 32'(rm)); end
      if (loadc) lc = k;
      if (loads) ls = k;
      if (asel)  asc = k;
      if (write) begin wr = k; chk("waddr", 32'(writenum), 32'(rd)); end
      if (done) begin lat = k; break; end
      @(negedge clk);
    end
    e_lat = (op == 2'b11) ? 3 : 4;
    chk("latency", 32'(lat), 32'(e_lat));
    chk("loada_cyc", 32'(la), (op == 2'b11) ? 32'd0 : 32'd1);
    chk("loadb_cyc", 32'(lb), 32'(e_lat - 2));
    chk("loadc_cyc", 32'(lc), 32'(e_lat - 1));
    chk("loads_cyc", 32'(ls), 32'(e_lat - 1));
    chk("asel_cyc", 32'(asc), (op == 2'b11) ? 32'(e_lat - 1) : 32'd0);
    chk("write_cyc", 32'(wr), wb ? 32'(e_lat) : 32'd0);
    chk("aluop_out", 32'(aluop), 32'(op));
    @(negedge clk);
  endtask

  task automatic exec_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rn,
                          input logic [2:0] rm, input logic wb);
    logic [15:0] r;
    r = ref_res(op, mdl_rf[rn], mdl_rf[rm]);
    run_cmd(op, rd, rn, rm, wb);
    if (wb) mdl_rf[rd] = r;
    mdl_cnt++;
    chk("rf_rd", 32'(rf[rd]), 32'(mdl_rf[rd]));
    chk("z_flag", 32'(z_r), 32'(r == 16'h0000));
    chk("op_count", 32'(op_count), 32'(mdl_cnt % 65536));
    chk("op_count_w2", 32'(op_count2), 32'(mdl_cnt % 4));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  rd, rn, rm;
    logic        wb;
    logic [15:0] val;
    logic        z;
  } vec_t;

  vec_t tbl [6];
  logic [15:0] pre [8];

  initial begin
    int g, acc, dn, base;
    int acc_t [3];
    int dn_t [3];
    int seq [5];
    logic [15:0] old;

    tbl[0] = '{2'd0, 3'd3, 3'd1, 3'd2, 1'b1, 16'h0001, 1'b0}; // add 0+1
    tbl[1] = '{2'd3, 3'd5, 3'd0, 3'd4, 1'b1, 16'h0001, 1'b0}; // not-B ~FFFE
    tbl[2] = '{2'd1, 3'd4, 3'd6, 3'd7, 1'b0, 16'hFFFE, 1'b1}; // compare 3-3, R4 untouched
    tbl[3] = '{2'd2, 3'd2, 3'd4, 3'd3, 1'b1, 16'h0000, 1'b1}; // FFFE & 1
    tbl[4] = '{2'd1, 3'd7, 3'd5, 3'd6, 1'b1, 16'hFFFE, 1'b0}; // 1-3
    tbl[5] = '{2'd0, 3'd1, 3'd4, 3'd4, 1'b1, 16'hFFFC, 1'b0}; // FFFE+FFFE
    pre = '{16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'hFFFE, 16'h0000, 16'h0003, 16'h0003};
    seq = '{1, 2, 3, 0, 1};

    // Reset held with a valid command pending: must be ignored
    reset_n = 1'b0; pl_en = 1'b0; pl_idx = 3'd0; pl_dat = 16'h0;
    cmd_valid = 1'b1; cmd_aluop = 2'd2; cmd_rd = 3'd0; cmd_rn = 3'd6; cmd_rm = 3'd7; cmd_wb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 3'(i); pl_dat = pre[i]; mdl_rf[i] = pre[i];
    end
    @(negedge clk);
    pl_en = 1'b0;
    mdl_cnt = 0;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_strobes", 32'({loada, loadb, loadc, loads, write, done, asel}), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    chk("rst_aluop", 32'(aluop), 32'd0);
    chk("rst_addrs", 32'({readnum, writenum}), 32'd0);

    // First accept on the first rising edge after release
    reset_n = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("first_accept", 32'(loada), 32'd1);
    g = 0;
    while (!done && g < 8) begin @(negedge clk); g++; end
    chk("first_done", 32'(done), 32'd1);
    @(negedge clk);
    mdl_rf[0] = 16'h0003;
    mdl_cnt = 1;
    chk("first_rf", 32'(rf[0]), 32'h3);
    chk("first_cnt", 32'(op_count), 32'd1);

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      exec_cmd(tbl[i].op, tbl[i].rd, tbl[i].rn, tbl[i].rm, tbl[i].wb);
      chk("tbl_val", 32'(rf[tbl[i].rd]), 32'(tbl[i].val));
      chk("tbl_z", 32'(z_r), 32'(tbl[i].z));
    end

    // cmd_valid held high across three commands
    @(negedge clk);
    g = 0;
    while (!cmd_ready && g < 20) begin @(negedge clk); g++; end
    base = mdl_cnt;
    cmd_valid = 1'b1; cmd_aluop = 2'd0; cmd_rd = 3'd5; cmd_rn = 3'd6; cmd_rm = 3'd7; cmd_wb = 1'b1;
    acc = 0; dn = 0;
    for (int t = 0; t < 40; t++) begin
      if (done && dn < 3) begin dn_t[dn] = t; dn++; end
      if (cmd_valid && cmd_ready && acc < 3) begin acc_t[acc] = t; acc++; end
      else if (acc == 3) cmd_valid = 1'b0;
      if (dn == 3) break;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd3);
    chk("b2b_dones", 32'(dn), 32'd3);
    if (acc == 3 && dn == 3) begin
      chk("b2b_acc_gap1", 32'(acc_t[1] - acc_t[0]), 32'd5);
      chk("b2b_acc_gap2", 32'(acc_t[2] - acc_t[1]), 32'd5);
      chk("b2b_done_gap1", 32'(dn_t[1] - dn_t[0]), 32'd5);
      chk("b2b_done_gap2", 32'(dn_t[2] - dn_t[1]), 32'd5);
      chk("b2b_latency", 32'(dn_t[0] - acc_t[0]), 32'd4);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) mdl_rf[5] = ref_res(2'd0, mdl_rf[6], mdl_rf[7]);
    mdl_cnt = base + 3;
    chk("b2b_count", 32'(op_count), 32'(mdl_cnt));
    chk("b2b_rf", 32'(rf[5]), 32'(mdl_rf[5]));

    // Reset while in LOAD_B discards the command
    g = 0;
    while (!cmd_ready && g < 20) begin @(negedge clk); g++; end
    old = mdl_rf[1];
    cmd_valid = 1'b1; cmd_aluop = 2'd0; cmd_rd = 3'd1; cmd_rn = 3'd2; cmd_rm = 3'd3; cmd_wb = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_in_loadb", 32'(loadb), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_strobes", 32'({loada, loadb, loadc, loads, write, done, asel}), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    mdl_cnt = 0;
    acc = 0;
    for (int t = 0; t < 8; t++) begin
      if (done || write) acc++;
      @(negedge clk);
    end
    chk("mid_no_done_write", 32'(acc), 32'd0);
    chk("mid_rf_kept", 32'(rf[1]), 32'(old));
    chk("mid_count", 32'(op_count), 32'd0);
    chk("mid_count_w2", 32'(op_count2), 32'd0);
    chk("mid_ready", 32'(cmd_ready), 32'd1);

    // Narrow counter wraps 1,2,3,0,1
    for (int i = 0; i < 5; i++) begin
      exec_cmd(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
      chk("cnt2_seq", 32'(op_count2), 32'(seq[i]));
    end

    // Random commands with random idle gaps
    for (int i = 0; i < 40; i++) begin
      g = int'($urandom_range(2, 0));
      for (int j = 0; j < g; j++) @(negedge clk);
      exec_cmd(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 8; i++) chk("final_rf", 32'(rf[i]), 32'(mdl_rf[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
